ps2_rx_ctrl: RTL and testbench

- Receive-side controller for the PS/2 keyboard port.
- Synchronises and glitch-filters raw PS/2 clock and data, and detects filtered clock falling edges.
- Sequences an 11-bit frame receive FSM, checks parity, stop bit and inter-bit timeout.
- Decodes F0/E0 prefixes into break/extended flags and presents one scan code per key event to the text-overlay input logic.

---
 rtl/ps2_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: sync, clock glitch filter, 11-bit frame FSM,
// F0/E0 prefix decode into one scan code per key event.
module ps2_rx_ctrl #(
    parameter int FILTER_CYCLES  = 51,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMER_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_raw,
    input  logic       ps2_data_raw,
    input  logic       rx_enable,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FCW-1:0] FMAX = FCW'(FILTER_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic           clk_s1_q, clk_s2_q;
    logic           dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_q, fall_d;

    state_t         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TIMER_W-1:0] wd_q;
    logic           brk_pend_q, ext_pend_q;
    logic           timeout;

    logic [7:0]     code_q;
    logic           valid_q, brk_q, ext_q, perr_q, ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_raw;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_raw;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Level only flips after FILTER_CYCLES consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FMAX) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            fall_q <= fall_d;
        end
    end

    assign timeout = (state_q != IDLE) && !fall_q && (wd_q == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (!rx_enable) begin
                state_q    <= IDLE;
                wd_q       <= '0;
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end else begin
                if (state_q == IDLE || fall_q) begin
                    wd_q <= '0;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
                if (timeout) begin
                    state_q    <= IDLE;
                    ferr_q     <= 1'b1;
                    brk_pend_q <= 1'b0;
                    ext_pend_q <= 1'b0;
                end else if (fall_q) begin
                    unique case (state_q)
                        IDLE: begin
                            if (!dat_s2_q) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end
                        DATA: begin
                            shift_q   <= {dat_s2_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= PARITY;
                            end
                        end
                        PARITY: begin
                            par_q   <= dat_s2_q;
                            state_q <= STOP;
                        end
                        STOP: begin
                            state_q <= IDLE;
                            if (!dat_s2_q) begin
                                ferr_q     <= 1'b1;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end else if (!(^{shift_q, par_q})) begin
                                perr_q     <= 1'b1;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end else if (shift_q == 8'hF0) begin
                                brk_pend_q <= 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_pend_q <= 1'b1;
                            end else begin
                                code_q     <= shift_q;
                                brk_q      <= brk_pend_q;
                                ext_q      <= ext_pend_q;
                                valid_q    <= 1'b1;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign code        = code_q;
    assign code_valid  = valid_q;
    assign is_break    = brk_q;
    assign is_extended = ext_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: frames driven bit by bit on the raw
// PS/2 pins, expected events queued and matched against output pulses.
module tb_ps2_rx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk_raw;
    logic       ps2_data_raw;
    logic       rx_enable;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];

    ps2_rx_ctrl #(
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(200),
        .TIMER_W       (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_raw (ps2_clk_raw),
        .ps2_data_raw(ps2_data_raw),
        .rx_enable   (rx_enable),
        .code        (code),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic [7:0] c,
                        input logic brk, input logic ext);
        ev_t e;
        e.kind = kind;
        e.code = c;
        e.brk  = brk;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    // kind: 100 = code_valid, 010 = parity_err, 001 = frame_err
    always @(negedge clk) begin
        if (rst_n && (code_valid || parity_err || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse",
                    {29'd0, code_valid, parity_err, frame_err}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind",
                    {29'd0, code_valid, parity_err, frame_err},
                    {29'd0, e.kind});
                if (e.kind == 3'b100) begin
                    chk("code", {24'd0, code}, {24'd0, e.code});
                    chk("is_break", {31'd0, is_break}, {31'd0, e.brk});
                    chk("is_ext", {31'd0, is_extended}, {31'd0, e.ext});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_clk_raw = 1'b1;
        wait_cyc(10);
        ps2_data_raw = b;
        wait_cyc(10);
        ps2_clk_raw = 1'b0;
        wait_cyc(20);
    endtask

    task automatic ps2_frame(input logic [7:0] b, input logic par,
                             input logic stop, input int nbits,
                             input int idle);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i]);
        end
        ps2_clk_raw = 1'b1;
        wait_cyc(10);
        ps2_data_raw = 1'b1;
        wait_cyc(idle);
    endtask

    task automatic good_frame(input logic [7:0] b);
        ps2_frame(b, ~^b, 1'b1, 11, 60);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'd0, code_valid}, 32'd0);
        chk({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        ps2_clk_raw  = 1'b1;
        ps2_data_raw = 1'b1;
        rx_enable    = 1'b1;
        wait_cyc(5);
        chk_quiet("reset");
        chk("reset_code", {24'd0, code}, 32'd0);
        chk("reset_brk", {31'd0, is_break}, 32'd0);
        chk("reset_ext", {31'd0, is_extended}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(10);

        push(3'b100, 8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);
        chk("busy_after_1C", {31'd0, busy}, 32'd0);

        good_frame(8'hE0);
        good_frame(8'hF0);
        push(3'b100, 8'h75, 1'b1, 1'b1);
        good_frame(8'h75);
        push(3'b100, 8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);

        // bad parity after a break prefix must also drop the prefix
        good_frame(8'hF0);
        push(3'b010, 8'h00, 1'b0, 1'b0);
        ps2_frame(8'h1C, 1'b1, 1'b1, 11, 60);
        push(3'b100, 8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);

        push(3'b001, 8'h00, 1'b0, 1'b0);
        ps2_frame(8'h1C, 1'b0, 1'b0, 11, 60);

        push(3'b001, 8'h00, 1'b0, 1'b0);
        ps2_frame(8'h1C, 1'b0, 1'b1, 5, 250);
        chk("busy_after_timeout", {31'd0, busy}, 32'd0);
        push(3'b100, 8'h5A, 1'b0, 1'b0);
        good_frame(8'h5A);

        for (int g = 0; g < 5; g++) begin
            ps2_clk_raw = 1'b0;
            wait_cyc(2);
            ps2_clk_raw = 1'b1;
            for (int k = 0; k < 10; k++) begin
                wait_cyc(1);
                chk("glitch_busy", {31'd0, busy}, 32'd0);
            end
        end

        ps2_data_raw = 1'b1;
        ps2_clk_raw  = 1'b0;
        wait_cyc(20);
        chk("data1_fall_busy", {31'd0, busy}, 32'd0);
        ps2_clk_raw = 1'b1;
        wait_cyc(40);

        ps2_frame(8'h1C, 1'b0, 1'b1, 4, 0);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        chk("async_reset_code", {24'd0, code}, 32'd0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(40);
        chk_quiet("after_reset");
        push(3'b100, 8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);

        good_frame(8'hE0);
        ps2_frame(8'h1C, 1'b0, 1'b1, 4, 0);
        rx_enable = 1'b0;
        wait_cyc(2);
        chk_quiet("disable");
        good_frame(8'h33);
        chk_quiet("disabled_frame");
        rx_enable = 1'b1;
        wait_cyc(20);
        push(3'b100, 8'h1C, 1'b0, 1'b0);
        good_frame(8'h1C);

        wait_cyc(50);
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
